// File: rtl/chunked_rc_adder.sv
// chunked_rc_adder: multi-cycle ripple-carry adder/subtractor.
// The operands are captured once. The block then adds CHUNK bits per clock,
// starting with the least-significant chunk. A carry register links each
// chunk to the next. Both the input and the output use valid/ready handshakes.
module chunked_rc_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    // The index needs at least one bit, even when the whole word is one chunk.
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;          // already inverted for subtract
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   res_q, res_d;      // partial result built chunk by chunk
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;

    // Chunked views of the captured operands.
    logic [CHUNK-1:0]   a_chunks [NCHUNK];
    logic [CHUNK-1:0]   b_chunks [NCHUNK];

    genvar gi;
    generate
        for (gi = 0; gi < NCHUNK; gi++) begin : g_chunk
            assign a_chunks[gi] = a_q[gi*CHUNK +: CHUNK];
            assign b_chunks[gi] = b_q[gi*CHUNK +: CHUNK];
        end
    endgenerate

    logic [CHUNK-1:0]   cur_a;
    logic [CHUNK-1:0]   cur_b;
    logic [CHUNK:0]     chunk_sum;
    logic [WIDTH-1:0]   res_merged;
    logic               last_chunk;

    // Select the active chunk, add it, and merge the sum into the partial result.
    always_comb begin
        cur_a      = '0;
        cur_b      = '0;
        res_merged = res_q;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_a = a_chunks[i];
                cur_b = b_chunks[i];
            end
        end
        chunk_sum = {1'b0, cur_a} + {1'b0, cur_b} + {{CHUNK{1'b0}}, carry_q};
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDX_W'(i)) begin
                res_merged[i*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
            end
        end
        last_chunk = (idx_q == IDX_W'(NCHUNK - 1));
    end

    // Compute the next state and the next register values.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        res_d       = res_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtraction uses a + ~b + 1, so cin is replaced by 1.
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d   = res_merged;
                carry_d = chunk_sum[CHUNK];
                if (last_chunk) begin
                    // Publish the result directly from the merged word,
                    // so that the final chunk is included in this cycle.
                    sum_d       = res_merged;
                    cout_d      = chunk_sum[CHUNK];
                    ovf_d       = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                  (res_merged[WIDTH-1] != a_q[WIDTH-1]);
                    out_valid_d = 1'b1;
                    idx_d       = '0;
                    state_d     = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Register the state. An asynchronous reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            res_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            res_q       <= res_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/chunked_rc_adder.md
Name: chunked_rc_adder

Overview:
Parametrised multi-cycle ripple-carry adder/subtractor. Adds CHUNK bits per clock, least-significant chunk first, carrying between chunks in a register. Uses a valid/ready handshake on both input and output. It is the sequential, width-generic successor to the single-bit full adder, for datapaths that trade latency for a short carry chain.

Parameters:
WIDTH, 16, operand and result width in bits; must be a multiple of CHUNK
CHUNK, 4, bits processed per cycle; 1 <= CHUNK <= WIDTH
NCHUNK (localparam), WIDTH/CHUNK, cycles spent in RUN

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands; equals (state==IDLE)
a  input  WIDTH  operand A, unsigned or two's complement
b  input  WIDTH  operand B
cin  input  1  carry-in; ignored when sub=1
sub  input  1  0: a+b+cin; 1: a-b (a + ~b + 1)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result
cout  output  1  carry-out of MSB; in subtract mode 1 = no borrow
ovf  output  1  signed overflow

Behaviour:
- Reset (rst_n=0, asynchronous, any state): state=IDLE; sum=0, cout=0, ovf=0, out_valid=0; in_ready=1; internal operand, carry and index registers cleared. Reset mid-operation aborts it, and no result is ever presented.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready at an edge:
  - capture A=a and B'=(sub ? ~b : b);
  - set carry=(sub ? 1 : cin), idx=0;
  - go to RUN.
  - in_valid without in_ready has no effect.
- RUN: in_ready=0. Each cycle:
  - compute {c, s} = A[idx*CHUNK +: CHUNK] + B'[idx*CHUNK +: CHUNK] + carry;
  - store s into the internal result chunk idx; carry <= c; idx <= idx+1.
  - After chunk NCHUNK-1 is processed, go to DONE.
- Entering DONE: sum <= full internal result, with the final chunk included; cout <= final carry; ovf <= (A[MSB]==B'[MSB]) && (result[MSB]!=A[MSB]); out_valid <= 1.
- Latency: out_valid rises exactly NCHUNK edges after the accepting edge. For CHUNK=WIDTH this is 1 edge.
- DONE: out_valid=1; sum, cout and ovf held stable. On out_valid&&out_ready, out_valid <= 0 and state goes to IDLE. in_ready is 1 the following cycle. There is no same-cycle output-to-input turnaround.
- Throughput: at most one operation per NCHUNK+2 cycles.
- sum, cout and ovf change only on entering DONE or on reset. Between operations they retain the last result.
- Wrap-around: the result is modulo 2^WIDTH. The carry beyond the MSB goes only to cout.
- in_valid, a, b, cin and sub are don't-care outside IDLE. Operands are captured, so input changes during RUN do not affect the result.
- out_ready is don't-care outside DONE.

Test Plan:
(WIDTH=16, CHUNK=4 unless noted)
1. Reset: hold rst_n=0, then release -> sum=0x0000, cout=0, ovf=0, out_valid=0, in_ready=1. Assert rst_n asynchronously between edges -> outputs clear immediately.
2. Add with latency check: a=0x00FF, b=0x0001, cin=0, sub=0, out_ready=1 -> out_valid exactly 4 edges after accept; sum=0x0100, cout=0, ovf=0. Then a=0xFFFF, b=0x0001, cin=1 -> sum=0x0001, cout=1, ovf=0.
3. Overflow and subtract:
   - a=0x7FFF + b=0x0001 -> sum=0x8000, cout=0, ovf=1.
   - sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, ovf=0.
   - sub=1, a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
   - sub=1 with cin=1, a=0x0005, b=0x0007 -> same result as cin=0 (cin ignored).
4. Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, sum, cout and ovf stable; in_ready=0. A new in_valid with different operands is not accepted. Raise out_ready -> handshake, in_ready=1 one cycle later, then the new operands are accepted.
5. Reset mid-RUN: accept a=0x1234, b=0x1111, drop rst_n after 2 cycles -> out_valid stays 0, in_ready=1. Next operation a=0x0003, b=0x0004 -> sum=0x0007 after 4 cycles, with no stale chunk from the aborted operation.
6. Parameter sweep: CHUNK=16 (latency 1), CHUNK=1 (latency 16), WIDTH=8/CHUNK=2 (latency 4). Run 1000 random a, b, cin, sub per configuration against the reference a+b+cin or a-b, checking sum, cout and ovf.
